// File: rtl/intr_ctrl.sv
// Interrupt controller for the KCPSM6: latches rising edges of upd_sysregs and db_btns[5:1]
// into a write-1-to-clear pending register, masks them, and sequences the interrupt handshake.
module intr_ctrl #(
    parameter logic [7:0] PA_PEND  = 8'h20,
    parameter logic [7:0] PA_MASK  = 8'h21,
    parameter logic [7:0] PA_MISS  = 8'h22,
    parameter logic [7:0] MASK_RST = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_sysregs,
    input  logic [5:0] db_btns,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [7:0] rd_data,
    output logic       rd_sel
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state, state_next;
    logic       upd_prev;
    logic [5:1] btn_prev;
    logic [7:0] pend, mask, miss;
    logic [7:0] pend_set, pend_clr, pend_next;
    logic       ev_upd;
    logic [5:1] ev_btn;
    logic       inc_miss;
    logic       wr_pend, wr_mask, wr_miss;
    logic       pend_wr_d;
    logic       pm_any;
    logic       btn0_unused;

    assign btn0_unused = db_btns[0];

    assign wr_pend = write_strobe && (port_id == PA_PEND);
    assign wr_mask = write_strobe && (port_id == PA_MASK);
    assign wr_miss = write_strobe && (port_id == PA_MISS);

    // A set in the same cycle as a clear of the same bit wins; bit 7 is never stored.
    always_comb begin
        ev_upd    = upd_sysregs & ~upd_prev;
        ev_btn    = db_btns[5:1] & ~btn_prev;
        inc_miss  = ev_upd & pend[0];
        pend_set  = {1'b0, inc_miss, ev_btn, ev_upd};
        pend_clr  = wr_pend ? out_port : 8'h00;
        pend_next = ((pend & ~pend_clr) | pend_set) & 8'h7F;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_prev  <= 1'b0;
            btn_prev  <= '0;
            pend      <= 8'h00;
            mask      <= MASK_RST;
            miss      <= 8'h00;
            pend_wr_d <= 1'b0;
        end else begin
            upd_prev  <= upd_sysregs;
            btn_prev  <= db_btns[5:1];
            pend      <= pend_next;
            pend_wr_d <= wr_pend;
            if (wr_mask)
                mask <= out_port;
            if (wr_miss)
                miss <= {7'd0, inc_miss};
            else if (inc_miss && (miss != 8'hFF))
                miss <= miss + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 8'h00;
            rd_sel  <= 1'b0;
        end else begin
            rd_data <= 8'h00;
            rd_sel  <= 1'b0;
            if (port_id == PA_PEND) begin
                rd_data <= pend;
                rd_sel  <= 1'b1;
            end else if (port_id == PA_MASK) begin
                rd_data <= mask;
                rd_sel  <= 1'b1;
            end else if (port_id == PA_MISS) begin
                rd_data <= miss;
                rd_sel  <= 1'b1;
            end
        end
    end

    assign pm_any = |(pend & mask);

    // SERVICE is left only once software has written PEND, so events arriving there wait for it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pm_any) state_next = REQ;
            REQ: begin
                if (interrupt_ack)
                    state_next = SERVICE;
                else if (!pm_any)
                    state_next = IDLE;
            end
            SERVICE: if (pend_wr_d) state_next = pm_any ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == REQ);
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scenario bench for intr_ctrl: interrupt levels are checked inline, read-back
// values go through an expectation queue that is drained as rd_data becomes valid.
module tb_intr_ctrl;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
        int         due;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       upd_sysregs;
    logic [5:0] db_btns;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] rd_data;
    logic       rd_sel;

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    rd_exp_t rd_q[$];
    rd_exp_t mon_r;
    logic    mon_sel;

    intr_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .upd_sysregs  (upd_sysregs),
        .db_btns      (db_btns),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .interrupt_ack(interrupt_ack),
        .interrupt    (interrupt),
        .rd_data      (rd_data),
        .rd_sel       (rd_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read scoreboard: each queued expectation is compared once its registered data is out.
    always @(negedge clk) begin
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            mon_r   = rd_q.pop_front();
            mon_sel = (mon_r.addr == 8'h20) || (mon_r.addr == 8'h21) || (mon_r.addr == 8'h22);
            total++;
            if (rd_data !== mon_r.exp || rd_sel !== mon_sel) begin
                bad++;
                $display("[TB] FAIL read_%h: rd_data=%h rd_sel=%b, expected rd_data=%h rd_sel=%b",
                         mon_r.addr, rd_data, rd_sel, mon_r.exp, mon_sel);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'hFF;
        out_port     = 8'h00;
    endtask

    task automatic issue_read(input logic [7:0] a, input logic [7:0] e);
        rd_q.push_back('{a, e, cyc + 1});
        port_id = a;
        tick();
        port_id = 8'hFF;
    endtask

    task automatic pulse_upd();
        upd_sysregs = 1'b1;
        tick();
        upd_sysregs = 1'b0;
        tick();
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; upd_sysregs = 1'b0; db_btns = '0; port_id = 8'hFF;
        out_port = 8'h00; write_strobe = 1'b0; interrupt_ack = 1'b0;
        #3;
        total++;
        if (interrupt !== 1'b0 || rd_data !== 8'h00 || rd_sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: irq=%b rd_data=%h rd_sel=%b, expected 0 00 0",
                     interrupt, rd_data, rd_sel);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        issue_read(8'h20, 8'h00);
        issue_read(8'h21, 8'h01);
        issue_read(8'h22, 8'h00);
    endtask

    task automatic test_basic();
        pulse_upd();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL basic_irq_up: interrupt=%b expected 1", interrupt);
        end
        issue_read(8'h20, 8'h01);
        ack_pulse();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_irq_ack: interrupt=%b expected 0", interrupt);
        end
        write_reg(8'h20, 8'h01);
        issue_read(8'h20, 8'h00);
        tick();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_idle: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_mask();
        write_reg(8'h21, 8'h01);
        db_btns = 6'b001000;
        tick();
        db_btns = '0;
        tick();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL mask_blocked: interrupt=%b expected 0", interrupt);
        end
        issue_read(8'h20, 8'h08);
        write_reg(8'h21, 8'h09);
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL mask_early: interrupt=%b expected 0", interrupt);
        end
        tick();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL mask_enable: interrupt=%b expected 1", interrupt);
        end
        ack_pulse();
        write_reg(8'h20, 8'hFF);
        tick();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL mask_cleanup: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_overrun();
        write_reg(8'h21, 8'h00);
        for (int i = 0; i < 3; i++) pulse_upd();
        issue_read(8'h20, 8'h41);
        issue_read(8'h22, 8'h02);
        for (int i = 0; i < 297; i++) pulse_upd();
        issue_read(8'h22, 8'hFF);
        write_reg(8'h22, 8'h5A);
        issue_read(8'h22, 8'h00);
        issue_read(8'h55, 8'h00);
        issue_read(8'h21, 8'h00);
        write_reg(8'h20, 8'hFF);
        issue_read(8'h20, 8'h00);
    endtask

    task automatic test_service_reassert();
        write_reg(8'h21, 8'h03);
        upd_sysregs = 1'b1;
        db_btns     = 6'b000010;
        tick();
        upd_sysregs = 1'b0;
        db_btns     = '0;
        tick();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL svc_irq_up: interrupt=%b expected 1", interrupt);
        end
        ack_pulse();
        tick(); tick(); tick();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL svc_hold: interrupt=%b expected 0", interrupt);
        end
        write_reg(8'h20, 8'h01);
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL svc_early: interrupt=%b expected 0", interrupt);
        end
        tick();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL svc_reassert: interrupt=%b expected 1", interrupt);
        end
        issue_read(8'h20, 8'h02);
        ack_pulse();
        write_reg(8'h20, 8'hFF);
        tick();
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL svc_cleanup: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_set_wins();
        write_reg(8'h21, 8'h00);
        db_btns = 6'b010000;
        tick();
        db_btns = '0;
        tick();
        db_btns = 6'b010000;
        write_reg(8'h20, 8'h10);
        db_btns = '0;
        issue_read(8'h20, 8'h10);
        write_reg(8'h20, 8'h10);
        issue_read(8'h20, 8'h00);
    endtask

    task automatic test_reset_mid();
        write_reg(8'h21, 8'h01);
        upd_sysregs = 1'b1;
        db_btns     = 6'b100000;
        tick();
        upd_sysregs = 1'b0;
        db_btns     = '0;
        tick();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_irq_up: interrupt=%b expected 1", interrupt);
        end
        #2;
        reset       = 1'b1;
        upd_sysregs = 1'b1;
        #1;
        total++;
        if (interrupt !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid_async: interrupt=%b expected 0", interrupt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        tick(); tick(); tick();
        total++;
        if (interrupt !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_event: interrupt=%b expected 1", interrupt);
        end
        issue_read(8'h20, 8'h01);
        issue_read(8'h22, 8'h00);
        upd_sysregs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_overrun();
        test_service_reassert();
        test_set_wins();
        test_reset_mid();
        tick(); tick();
        if (rd_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL read_drain: pending=%0d expected 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
